// File: rtl/otp_pkg.sv
// otp_pkg: shared constants, UART FSM states and frame byte builder for the OTP frame transmitter.
package otp_pkg;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int FRAME_BYTES = 4;
    localparam int DATA_W = 8;
    localparam int IDX_W = 3;
    localparam int ENTRY_W = DATA_W + IDX_W + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

    // entry layout is {decrypt, index, data}; byte 3 is the XOR checksum of bytes 0..2
    function automatic logic [7:0] frame_byte(input logic [7:0] sync, input logic [ENTRY_W-1:0] e,
                                              input logic [1:0] n);
        logic [7:0] b1, b2;
        b1 = {e[ENTRY_W-1], 4'b0000, e[DATA_W+IDX_W-1:DATA_W]};
        b2 = e[DATA_W-1:0];
        return n == 2'd0 ? sync : n == 2'd1 ? b1 : n == 2'd2 ? b2 : sync ^ b1 ^ b2;
    endfunction
endpackage

// File: rtl/otp_frame_tx_if.sv
// otp_frame_tx_if: valid/ready entry handshake from the encryptor into the frame transmitter.
interface otp_frame_tx_if;
    import otp_pkg::*;
    logic               in_valid;
    logic [DATA_W-1:0]  in_data;
    logic [IDX_W-1:0]   in_index;
    logic               in_decrypt;
    logic               in_ready;

    modport master (output in_valid, in_data, in_index, in_decrypt, input in_ready);
    modport slave  (input in_valid, in_data, in_index, in_decrypt, output in_ready);
endinterface

// File: rtl/uart_tx_8n1.sv
// uart_tx_8n1: 8N1 serialiser; load_i is taken in IDLE or on the last stop-bit cycle for back-to-back bytes.
module uart_tx_8n1 import otp_pkg::*; #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [7:0] byte_i,
    output logic       tx_o,
    output logic       done_o,
    output logic       idle_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    uart_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          tick;

    assign tick   = cnt_q == CW'(CLKS_PER_BIT - 1);
    assign done_o = state_q == STOP && tick;
    assign idle_o = state_q == IDLE;
    assign tx_o   = state_q == START ? 1'b0 : state_q == DATA ? sh_q[0] : 1'b1;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        cnt_d   = (state_q == IDLE || tick) ? '0 : cnt_q + 1'b1;
        case (state_q)
            IDLE:  if (load_i) begin
                state_d = START;
                sh_d    = byte_i;
            end
            START: if (tick) begin
                state_d = DATA;
                bit_d   = '0;
            end
            DATA:  if (tick) begin
                sh_d    = sh_q >> 1;
                bit_d   = bit_q + 1'b1;
                state_d = bit_q == 3'd7 ? STOP : DATA;
            end
            STOP:  if (tick) begin
                state_d = load_i ? START : IDLE;
                sh_d    = load_i ? byte_i : sh_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
        end
    end
endmodule

// File: rtl/otp_frame_tx.sv
// otp_frame_tx: buffers OTP entries in a show-ahead FIFO and sends each as a 4-byte UART frame
// (sync, header, data, checksum).
module otp_frame_tx import otp_pkg::*; #(
    parameter int         CLKS_PER_BIT = 87,
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    otp_frame_tx_if.slave                 in_if,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]      rd_q, wr_q;
    logic [LW-1:0]      cnt_q;
    logic [ENTRY_W-1:0] frame_q;
    logic [1:0]         byte_q;
    logic               ovf_q;
    logic               push, pop, load, done, tx_idle, more, last;
    logic [7:0]         byte_d;

    assign in_if.in_ready = cnt_q != LW'(FIFO_DEPTH);
    assign push       = in_if.in_valid & in_if.in_ready;
    assign more       = ena & (cnt_q != '0);
    assign last       = byte_q == 2'(FRAME_BYTES - 1);
    // a new frame starts from idle or straight after the checksum byte's stop bit
    assign pop        = more & (tx_idle | (done & last));
    assign load       = pop | (done & !last);
    assign byte_d     = pop ? SYNC_BYTE : frame_byte(SYNC_BYTE, frame_q, byte_q + 2'd1);
    assign busy       = !tx_idle | (cnt_q != '0);
    assign overflow   = ovf_q;
    assign fifo_level = cnt_q;

    uart_tx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .byte_i (byte_d),
        .tx_o   (tx),
        .done_o (done),
        .idle_o (tx_idle)
    );

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {in_if.in_decrypt, in_if.in_index, in_if.in_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            frame_q <= '0;
            byte_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            rd_q    <= pop ? rd_q + 1'b1 : rd_q;
            wr_q    <= push ? wr_q + 1'b1 : wr_q;
            cnt_q   <= cnt_q + LW'(push) - LW'(pop);
            frame_q <= pop ? mem_q[rd_q] : frame_q;
            byte_q  <= done ? byte_q + 2'd1 : byte_q;
            ovf_q   <= ovf_q | (in_if.in_valid & !in_if.in_ready);
        end
    end
endmodule

// File: tb/tb_otp_frame_tx.sv
// tb_otp_frame_tx: cycle-accurate frame/queue model plus a UART decoder checking otp_frame_tx.
module tb_otp_frame_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic clk = 0, rst_n = 0, ena = 0;
    logic tx, busy, overflow;
    logic [2:0] fifo_level;
    int checks = 0, errors = 0, cyc = 0, c_push = 0;

    otp_frame_tx_if bus();

    otp_frame_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_if(bus.slave),
        .tx(tx), .busy(busy), .overflow(overflow), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at cyc %0d", n, a, e, cyc);
        end
    endtask

    // behavioural model: queue of entries, a frame is 40 bit-slots of CPB cycles each
    logic [11:0] m_q[$];
    logic [11:0] m_cur;
    logic m_act = 0, m_ovf = 0, m_ok, m_fin, m_st;
    int m_t = 0;

    function automatic logic [7:0] mbyte(input logic [11:0] e, input int n);
        logic [7:0] b1 = {e[11], 4'h0, e[10:8]};
        logic [7:0] b2 = e[7:0];
        case (n)
            0: return 8'hA5;
            1: return b1;
            2: return b2;
            default: return 8'hA5 ^ b1 ^ b2;
        endcase
    endfunction

    function automatic logic exp_tx();
        int k;
        logic [7:0] by;
        if (!m_act) return 1'b1;
        k = m_t / CPB;
        if (k % 10 == 0) return 1'b0;
        if (k % 10 == 9) return 1'b1;
        by = mbyte(m_cur, k / 10);
        return by[k % 10 - 1];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_act = 0;
            m_t = 0;
            m_ovf = 0;
        end else begin
            m_ok  = bus.in_valid && m_q.size() < DEPTH;
            if (bus.in_valid && !m_ok) m_ovf = 1;
            m_fin = m_act && m_t == 40 * CPB - 1;
            m_st  = (!m_act || m_fin) && m_q.size() > 0 && ena;
            if (m_st) begin
                m_cur = m_q.pop_front();
                m_act = 1;
                m_t = 0;
            end else if (m_fin) m_act = 0;
            else if (m_act) m_t++;
            if (m_ok) m_q.push_back({bus.in_decrypt, bus.in_index, bus.in_data});
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("tx", tx, exp_tx());
            chk("busy", busy, m_act || m_q.size() != 0);
            chk("level", fifo_level, m_q.size());
            chk("in_ready", bus.in_ready, m_q.size() < DEPTH);
            chk("overflow", overflow, m_ovf);
        end
    end

    // UART receiver sampling one cycle into each bit
    logic [7:0] rx_q[$];
    logic [7:0] rb;
    initial forever begin
        @(negedge clk);
        if (rst_n && tx == 1'b0) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                rb[i] = tx;
            end
            repeat (CPB) @(negedge clk);
            if (tx) rx_q.push_back(rb);
        end
    end

    task automatic offer(input logic [7:0] d, input logic [2:0] i, input logic dc);
        bus.in_valid = 1;
        bus.in_data = d;
        bus.in_index = i;
        bus.in_decrypt = dc;
    endtask

    task automatic push1(input logic [7:0] d, input logic [2:0] i, input logic dc);
        @(negedge clk);
        offer(d, i, dc);
        c_push = cyc + 1;
        @(negedge clk);
        bus.in_valid = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic chk_rx(input string n, input int base, input logic [7:0] e0, e1, e2, e3);
        logic [7:0] e[4] = '{e0, e1, e2, e3};
        for (int i = 0; i < 4; i++) chk(n, rx_q.size() > base + i ? rx_q[base + i] : 8'hxx, e[i]);
    endtask

    int c0, maxlv;

    initial begin
        bus.in_valid = 0;
        bus.in_data = 0;
        bus.in_index = 0;
        bus.in_decrypt = 0;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_ovf", overflow, 0);
        rst_n = 1;

        // single frame latency, content and length
        ena = 1;
        rx_q.delete();
        push1(8'h3C, 3'd5, 1'b0);
        chk("t1_pre", tx, 1);
        @(negedge clk);
        chk("t1_latency", tx, 0);
        wait_idle();
        chk("t1_len", cyc - (c_push + 1), 160);
        chk("t1_nbytes", rx_q.size(), 4);
        chk_rx("t1_byte", 0, 8'hA5, 8'h05, 8'h3C, 8'h9C);

        rx_q.delete();
        push1(8'h00, 3'd2, 1'b1);
        wait_idle();
        chk_rx("t2_byte", 0, 8'hA5, 8'h82, 8'h00, 8'h27);

        // six back-to-back offers overflow a 4-deep FIFO
        rx_q.delete();
        maxlv = 0;
        @(negedge clk);
        c0 = cyc;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            maxlv = fifo_level > maxlv ? fifo_level : maxlv;
            if (k == 5) chk("t3_ready6", bus.in_ready, 0);
            offer(8'h40 + 8'(k), 3'(k), k[0]);
        end
        @(negedge clk);
        bus.in_valid = 0;
        chk("t3_maxlevel", maxlv, 4);
        chk("t3_ovf", overflow, 1);
        wait_idle();
        chk("t3_len", cyc - (c0 + 2), 800);
        chk("t3_nbytes", rx_q.size(), 20);
        chk("t3_last_data", rx_q.size() > 18 ? rx_q[18] : 8'hxx, 8'h44);

        // ena gates only frame starts
        ena = 0;
        push1(8'h71, 3'd1, 1'b0);
        push1(8'h72, 3'd2, 1'b0);
        repeat (10) @(negedge clk);
        chk("t4_hold_tx", tx, 1);
        chk("t4_hold_busy", busy, 1);
        ena = 1;
        @(negedge clk);
        chk("t4_start", tx, 0);
        repeat (60) @(negedge clk);
        ena = 0;
        repeat (200) @(negedge clk);
        chk("t4_stopped_tx", tx, 1);
        chk("t4_left", fifo_level, 1);
        ena = 1;
        wait_idle();

        // asynchronous reset in the middle of the data byte
        push1(8'h12, 3'd1, 1'b0);
        c0 = c_push;
        push1(8'h13, 3'd1, 1'b0);
        push1(8'h14, 3'd1, 1'b0);
        while (cyc < c0 + 96) @(negedge clk);
        chk("t5_pre_level", fifo_level, 2);
        #2 rst_n = 0;
        #1;
        chk("t5_rst_tx", tx, 1);
        chk("t5_rst_level", fifo_level, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_ovf", overflow, 0);
        chk("t5_rst_ready", bus.in_ready, 1);
        @(negedge clk);
        rst_n = 1;
        repeat (50) @(negedge clk);
        rx_q.delete();
        push1(8'h5A, 3'd7, 1'b1);
        wait_idle();
        chk("t5_nbytes", rx_q.size(), 4);
        chk_rx("t5_byte", 0, 8'hA5, 8'h87, 8'h5A, 8'h78);

        // push and pop on the same edge keep level and order
        rx_q.delete();
        ena = 0;
        push1(8'h11, 3'd1, 1'b0);
        push1(8'h22, 3'd2, 1'b0);
        @(negedge clk);
        ena = 1;
        offer(8'h33, 3'd3, 1'b0);
        @(negedge clk);
        bus.in_valid = 0;
        chk("t6_level", fifo_level, 2);
        wait_idle();
        chk("t6_d0", rx_q.size() > 2 ? rx_q[2] : 8'hxx, 8'h11);
        chk("t6_d1", rx_q.size() > 6 ? rx_q[6] : 8'hxx, 8'h22);
        chk("t6_d2", rx_q.size() > 10 ? rx_q[10] : 8'hxx, 8'h33);

        // random traffic against the model
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data = 8'($urandom);
            bus.in_index = 3'($urandom);
            bus.in_decrypt = 1'($urandom);
            ena = $urandom_range(0, 3) != 0;
        end
        @(negedge clk);
        bus.in_valid = 0;
        ena = 1;
        wait_idle();
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/otp_frame_tx.md
Name: otp_frame_tx

Overview:
Downstream stage of the OTP encryptor. It consumes each ciphertext/plaintext byte and its pad index, buffers them in a small FIFO, and wraps each one into a 4-byte frame: sync, header, data, checksum. Frames are sent on a single UART 8N1 serial line, so an off-chip host can capture the output stream without sampling uo_out every cycle.

Parameters:
CLKS_PER_BIT, 87, clock cycles per UART bit (10 MHz / 115200); must be >= 2
FIFO_DEPTH, 4, number of buffered entries; must be a power of 2, >= 2
SYNC_BYTE, 8'hA5, first byte of every frame

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
ena  input  1  design enable; when low, no new frame starts
in_valid  input  1  entry present on in_* this cycle
in_data  input  8  encrypted/decrypted byte
in_index  input  3  pad index for this byte
in_decrypt  input  1  1 = entry came from decrypt path
in_ready  output  1  FIFO not full; an entry is accepted on an edge where in_valid & in_ready
tx  output  1  UART serial out, idle high
busy  output  1  frame in progress or FIFO non-empty
overflow  output  1  sticky: an entry was offered while in_ready was low
fifo_level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset, asynchronous on rst_n low, effective immediately even mid-frame:
  - tx=1, busy=0, overflow=0, fifo_level=0, in_ready=1.
  - FIFO emptied and FSM forced to IDLE.
  - No partial frame resumes after reset.
- FIFO:
  - Show-ahead; each entry is {in_decrypt, in_index, in_data}, 12 bits.
  - in_ready = !full, driven from registered occupancy.
  - A pop on the same edge does not make room for a push on that edge.
  - A push and a pop on the same edge leave fifo_level unchanged.
- overflow: set on any edge with in_valid & !in_ready. The offered entry is dropped. Cleared only by reset.
- Frame bytes, in order:
  - B0 = SYNC_BYTE
  - B1 = {in_decrypt, 4'b0000, in_index}
  - B2 = in_data
  - B3 = B0 ^ B1 ^ B2
- UART framing: each byte is 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit is held exactly CLKS_PER_BIT cycles.
- FSM states:
  - IDLE: tx=1. If FIFO non-empty and ena=1: pop the entry, latch it into the frame register, load B0, go to START, and drive tx=0 on that same edge.
  - START: after CLKS_PER_BIT cycles go to DATA, bit counter = 0.
  - DATA: shift out one bit per CLKS_PER_BIT cycles. After bit 7 go to STOP.
  - STOP: after CLKS_PER_BIT cycles:
    - if byte counter < 3: increment it, load the next byte, go to START (no idle gap).
    - else if FIFO non-empty and ena=1: pop and start the next frame immediately (B0 of the next frame follows back-to-back).
    - else go to IDLE.
- Latency: entry accepted on edge N into an empty FIFO with FSM in IDLE and ena=1 gives tx=0 after edge N+1.
- Frame length: exactly 40*CLKS_PER_BIT cycles.
- ena low mid-frame: the current frame completes. Only new frame starts are blocked. FIFO accepts entries regardless of ena.
- Byte counter wraps 3 -> 0 at frame end. Baud counter reloads at every bit boundary.
- busy = (state != IDLE) | (fifo_level != 0).

Decomposition:
- Shared package otp_pkg holds:
  - SYNC_BYTE default
  - FSM state enum {IDLE, START, DATA, STOP}
  - FRAME_BYTES = 4
  - entry field widths (data 8, index 3)
- One natural sub-module, uart_tx_8n1:
  - baud counter plus start/data/stop shifting
  - handshake: load strobe plus byte in; done pulse out
- otp_frame_tx keeps the FIFO, frame byte sequencing and checksum.

Test Plan:
1. CLKS_PER_BIT=4. Push in_data=0x3C, in_index=5, in_decrypt=0 once -> tx low after edge N+1; decoded bytes A5,05,3C,9C; frame lasts 160 cycles; then IDLE, busy=0.
2. Push in_data=0x00, in_index=2, in_decrypt=1 -> bytes A5,82,00,27.
3. Push 6 entries on consecutive edges -> entries 1–5 accepted; fifo_level peaks at 4; in_ready=0 on the 6th; overflow=1; 5 frames sent back-to-back with no idle bits, 800 cycles total.
4. ena=0 with 2 entries queued -> tx stays 1, busy=1. Raise ena -> frames start on the next edge. Drop ena mid-frame -> that frame completes and the second does not start.
5. Assert rst_n=0 during DATA of B2 -> tx=1 and fifo_level=0 immediately without a clock. After release, a new push produces a clean frame starting with A5.
6. Simultaneous push and pop at fifo_level=2 -> level stays 2; entry order is preserved, checked by the data sequence 0x11,0x22,0x33.
